// File: rtl/ifft4_stream.sv
`default_nettype none
// =============================================================================
//  Module   : ifft4_stream
//  Brief    : Streaming 4-point inverse DFT with 1/4 scale and OW-bit saturation.
//             Define IFFT4_ROUND_EN for round-half-up scaling (default truncates).
//  Revision : 1.0
// =============================================================================
module ifft4_stream #(
  parameter int IW = 18,
  parameter int OW = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*IW-1:0] in_data,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*OW-1:0] out_data,
  output logic            out_last,
  output logic            err,
  output logic            sat
);

  localparam int SW = IW + 2;

`ifdef IFFT4_ROUND_EN
  localparam logic [SW:0] RND = (SW+1)'(2);
`endif

  logic [2*IW-1:0] in_buf  [4];
  logic [2*OW-1:0] out_buf [4];
  logic [1:0]      wi;
  logic [1:0]      ri;
  logic            in_full;
  logic            out_full;

  logic            in_hs;
  logic            out_hs;
  logic            out_done;
  logic            compute;

  logic [SW-1:0]   br [4];
  logic [SW-1:0]   bi [4];
  logic [SW-1:0]   yr [4];
  logic [SW-1:0]   yi [4];
  logic [OW:0]     qr [4];
  logic [OW:0]     qi [4];
  logic            any_sat;

  // Returns {clamped, value}: >>>2 (optionally rounded) then saturate to OW bits.
  function automatic logic [OW:0] scale_sat(input logic [SW-1:0] v);
    logic [SW:0]   t;
    logic [SW-2:0] s;
    logic [OW:0]   r;
`ifdef IFFT4_ROUND_EN
    t = {v[SW-1], v} + RND;
`else
    t = {v[SW-1], v};
`endif
    s = t[SW:2];
    if ((&s[SW-2:OW-1]) || !(|s[SW-2:OW-1]))
      r = {1'b0, s[OW-1:0]};
    else if (s[SW-2])
      r = {1'b1, 1'b1, {(OW-1){1'b0}}};
    else
      r = {1'b1, 1'b0, {(OW-1){1'b1}}};
    return r;
  endfunction

  assign in_ready = !in_full;
  assign in_hs    = in_valid & !in_full;
  assign out_hs   = out_full & out_ready;
  assign out_done = out_hs & (ri == 2'd3);
  // Refill on the edge the last sample leaves so frames drain back to back.
  assign compute  = in_full & (!out_full | out_done);

  assign out_valid = out_full;
  assign out_data  = out_buf[ri];
  assign out_last  = out_full & (ri == 2'd3);

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      br[k] = {{(SW-IW){in_buf[k][IW-1]}},   in_buf[k][IW-1:0]};
      bi[k] = {{(SW-IW){in_buf[k][2*IW-1]}}, in_buf[k][2*IW-1:IW]};
    end
    // j*(R,I) = (-I,R); inverse transform uses +j for x1 and -j for x3.
    yr[0] = br[0] + br[1] + br[2] + br[3];
    yi[0] = bi[0] + bi[1] + bi[2] + bi[3];
    yr[1] = br[0] - bi[1] - br[2] + bi[3];
    yi[1] = bi[0] + br[1] - bi[2] - br[3];
    yr[2] = br[0] - br[1] + br[2] - br[3];
    yi[2] = bi[0] - bi[1] + bi[2] - bi[3];
    yr[3] = br[0] + bi[1] - br[2] - bi[3];
    yi[3] = bi[0] - br[1] - bi[2] + br[3];
    any_sat = 1'b0;
    for (int k = 0; k < 4; k++) begin
      qr[k]   = scale_sat(yr[k]);
      qi[k]   = scale_sat(yi[k]);
      any_sat = any_sat | qr[k][OW] | qi[k][OW];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wi      <= 2'd0;
      in_full <= 1'b0;
      err     <= 1'b0;
    end else begin
      err <= 1'b0;
      if (in_hs) begin
        if (in_last && (wi != 2'd3)) begin
          err <= 1'b1;
          wi  <= 2'd0;
        end else begin
          wi <= wi + 2'd1;
          if (wi == 2'd3) begin
            in_full <= 1'b1;
            err     <= !in_last;
          end
        end
      end else if (compute) begin
        in_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_hs)
      in_buf[wi] <= in_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ri       <= 2'd0;
      out_full <= 1'b0;
      sat      <= 1'b0;
      for (int k = 0; k < 4; k++)
        out_buf[k] <= '0;
    end else begin
      sat <= 1'b0;
      if (compute) begin
        out_full <= 1'b1;
        ri       <= 2'd0;
        sat      <= any_sat;
        for (int k = 0; k < 4; k++)
          out_buf[k] <= {qi[k][OW-1:0], qr[k][OW-1:0]};
      end else if (out_hs) begin
        ri <= ri + 2'd1;
        if (ri == 2'd3)
          out_full <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
